mux_reduce_engine: RTL and testbench
====================================

# mux_reduce_engine

Parametrised, time-multiplexed bitwise reduction engine. It accepts N_CH channels of WIDTH bits in one upstream transfer and folds them one channel per cycle into a WIDTH-bit result using OR, AND or XOR. All logic operators are built from 2:1 mux primitives. It is the sequential, multi-channel, multi-mode successor to the single-bit mux-built gate, and sits between a valid/ready producer and consumer.

## Interface
- WIDTH, default 8: bits per channel and result width; must be at least 1.
- N_CH, default 4: number of channels; must be at least 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- up_vld  input  1  upstream data valid.
- up_rdy  output  1  engine can accept; high only in IDLE.
- up_data  input  N_CH*WIDTH  channel i at up_data[i*WIDTH +: WIDTH].
- up_mode  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 reserved (executes as OR).
- down_vld  output  1  result valid.
- down_rdy  input  1  consumer accepts result.
- down_data  output  WIDTH  reduction result.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - down_vld = 0, down_data = 0, busy = 0.
  - up_rdy = 1, decoded combinationally from IDLE.
  - Accumulator, index, captured data and mode all reset to 0.
- IDLE:
  - up_rdy = 1.
  - On up_vld && up_rdy: capture up_data and up_mode, load acc = ch[0], idx = 1.
  - Next state is RUN if N_CH > 1, else DONE.
- RUN:
  - Each cycle: acc = op(acc, ch[idx]) and idx = idx + 1.
  - After the cycle that processes ch[N_CH-1], go to DONE.
  - up_vld is ignored in this state.
- DONE:
  - down_vld = 1 and down_data = acc.
  - Both are held stable until down_rdy.
  - On down_vld && down_rdy, return to IDLE. No same-cycle new acceptance.
- op per bit, mux form:
  - OR: y = a ? 1 : b.
  - AND: y = a ? b : 0.
  - XOR: y = a ? ~b : b.
- Index counter width: $clog2(N_CH) bits, minimum 1. idx never exceeds N_CH-1 and does not wrap.
- Mode is latched at acceptance. Changes on up_mode after acceptance have no effect.
- Reset at any point (mid-RUN or in DONE) immediately returns the block to IDLE with reset values. The partial result is discarded and never presented.

## Timing
- Acceptance edge T. down_vld is high after edge T+N_CH-1.
- For N_CH = 1, down_vld is high after edge T.
- Minimum initiation interval: N_CH+1 cycles. That is N_CH-1 RUN cycles, plus DONE, plus IDLE.
- up_rdy and busy are registered-state decodes, with no combinational path from up_vld or down_rdy.
- down_data is registered and changes only when entering DONE or on reset.
- Reset is asynchronous assert. The design tolerates deassertion synchronised externally to clk.

## Structure
- Package mux_reduce_pkg holds:
  - the mode enum (MODE_OR, MODE_AND, MODE_XOR, MODE_RSVD);
  - the state enum (S_IDLE, S_RUN, S_DONE).
- One sub-module, mux2_w: a WIDTH-parametrised 2:1 mux.
  - The engine instantiates it for the per-bit operator network.
  - It also instantiates it as a tree for the channel selector ch[idx].
- The top level contains the FSM, accumulator, index counter and captured input register.

## Test plan
All scenarios use WIDTH=8, N_CH=4 unless noted.
- OR: channels 0x01, 0x02, 0x04, 0x80 with mode 00 -> down_data 0x87; down_vld rises 3 cycles after the acceptance edge.
- AND: channels 0xFF, 0xF0, 0x3C, 0xFE with mode 01 -> 0x30. Reserved mode 11 with the OR vectors -> 0x87.
- XOR: channels 0xAA, 0x55, 0xFF, 0x0F with mode 10 -> 0x0F.
  - Toggling up_mode during RUN does not change the result.
- Backpressure: hold down_rdy = 0 for 5 cycles in DONE.
  - down_vld and down_data stay stable; up_rdy stays 0.
  - A concurrent up_vld is not accepted.
  - After down_rdy, up_rdy = 1 on the next cycle.
- Reset mid-RUN: assert rst 2 cycles after acceptance.
  - down_vld = 0, busy = 0, up_rdy = 1 immediately, with no clock edge needed.
  - The following OR transaction still returns 0x87.
- N_CH=1 instance: channel 0x5A in any mode -> down_data 0x5A, down_vld high one edge after acceptance.

Source files
------------

// File: rtl/mux_reduce_pkg.sv
// Shared types for the mux-built reduction engine.
//   mode_t  : reduction operator selected at acceptance (11 behaves as OR)
//   state_t : engine control states
//   idx_width() : channel index width, never narrower than one bit
package mux_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_OR   = 2'b00,
        MODE_AND  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_reduce_engine_mux2_w.sv
// WIDTH-bit 2:1 mux with an independent select per bit.
//   sel : per-bit select (replicate one bit for a whole-word mux)
//   d0  : chosen where sel bit is 0
//   d1  : chosen where sel bit is 1
//   y   : result
module mux2_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = sel[gi] ? d1[gi] : d0[gi];
        end
    endgenerate

endmodule

// File: rtl/mux_reduce_engine.sv
// Time-multiplexed bitwise reduction engine. One upstream transfer carries
// N_CH channels; they are folded one per cycle into a WIDTH-bit result with
// OR / AND / XOR, every operator being built from 2:1 muxes.
//   clk, rst              : clock, asynchronous active-high reset
//   up_vld/up_rdy         : upstream handshake (ready only in IDLE)
//   up_data, up_mode      : channels (ch i at [i*WIDTH +: WIDTH]) and operator
//   down_vld/down_rdy     : result handshake (valid only in DONE)
//   down_data             : registered reduction result
//   busy                  : high in RUN or DONE
import mux_reduce_pkg::*;

module mux_reduce_engine #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_vld,
    output logic                  up_rdy,
    input  logic [N_CH*WIDTH-1:0] up_data,
    input  logic [1:0]            up_mode,
    output logic                  down_vld,
    input  logic                  down_rdy,
    output logic [WIDTH-1:0]      down_data,
    output logic                  busy
);

    localparam int IW     = idx_width(N_CH);
    localparam int LEAVES = 1 << IW;
    localparam logic [IW-1:0]    IDX_FIRST = (N_CH > 1) ? IW'(1) : '0;
    localparam logic [IW-1:0]    IDX_LAST  = IW'(N_CH - 1);
    localparam logic [IW-1:0]    IDX_STEP  = IW'(1);
    localparam logic [WIDTH-1:0] ALL1      = '1;
    localparam logic [WIDTH-1:0] ALL0      = '0;

    state_t                  state_reg;
    mode_t                   mode_reg;
    logic [N_CH*WIDTH-1:0]   cap_reg;
    logic [WIDTH-1:0]        acc_reg;
    logic [WIDTH-1:0]        down_data_reg;
    logic [IW-1:0]           idx_reg;

    // Channel selector: heap-ordered mux tree, node 0 is the root and the
    // root level is steered by the idx MSB. Unused leaves are tied to zero.
    logic [WIDTH-1:0] node [0:2*LEAVES-2];
    logic [WIDTH-1:0] ch_sel;

    genvar gi, gl, gn;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < N_CH) begin : g_used
                assign node[LEAVES-1+gi] = cap_reg[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign node[LEAVES-1+gi] = ALL0;
            end
        end
        for (gl = 0; gl < IW; gl++) begin : g_level
            for (gn = 0; gn < (1 << gl); gn++) begin : g_node
                localparam int K = (1 << gl) - 1 + gn;
                mux2_w #(.WIDTH(WIDTH)) u_sel (
                    .sel ({WIDTH{idx_reg[IW-1-gl]}}),
                    .d0  (node[2*K+1]),
                    .d1  (node[2*K+2]),
                    .y   (node[K])
                );
            end
        end
    endgenerate

    assign ch_sel = node[0];

    // Operator network: the accumulator bit steers each mux.
    logic [WIDTH-1:0] ch_inv, or_y, and_y, xor_y, and_or_y, op_y;
    logic             is_and, is_xor;

    assign ch_inv = ~ch_sel;
    assign is_and = (mode_reg == MODE_AND);
    assign is_xor = (mode_reg == MODE_XOR);

    mux2_w #(.WIDTH(WIDTH)) u_or  (.sel(acc_reg), .d0(ch_sel), .d1(ALL1),   .y(or_y));
    mux2_w #(.WIDTH(WIDTH)) u_and (.sel(acc_reg), .d0(ALL0),   .d1(ch_sel), .y(and_y));
    mux2_w #(.WIDTH(WIDTH)) u_xor (.sel(acc_reg), .d0(ch_sel), .d1(ch_inv), .y(xor_y));

    // Reserved mode falls through to OR because neither select is set.
    mux2_w #(.WIDTH(WIDTH)) u_m_and (.sel({WIDTH{is_and}}), .d0(or_y),     .d1(and_y), .y(and_or_y));
    mux2_w #(.WIDTH(WIDTH)) u_m_xor (.sel({WIDTH{is_xor}}), .d0(and_or_y), .d1(xor_y), .y(op_y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            mode_reg      <= MODE_OR;
            cap_reg       <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
            down_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (up_vld) begin
                        cap_reg  <= up_data;
                        mode_reg <= mode_t'(up_mode);
                        acc_reg  <= up_data[WIDTH-1:0];
                        idx_reg  <= IDX_FIRST;
                        if (N_CH > 1) begin
                            state_reg <= S_RUN;
                        end else begin
                            state_reg     <= S_DONE;
                            down_data_reg <= up_data[WIDTH-1:0];
                        end
                    end
                end
                S_RUN: begin
                    acc_reg <= op_y;
                    // Stop at the last channel rather than wrapping the index.
                    if (idx_reg == IDX_LAST) begin
                        state_reg     <= S_DONE;
                        down_data_reg <= op_y;
                    end else begin
                        idx_reg <= idx_reg + IDX_STEP;
                    end
                end
                S_DONE: begin
                    if (down_rdy) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign up_rdy    = (state_reg == S_IDLE);
    assign down_vld  = (state_reg == S_DONE);
    assign busy      = (state_reg == S_RUN) || (state_reg == S_DONE);
    assign down_data = down_data_reg;

endmodule

// File: tb/tb_mux_reduce_engine.sv
module tb_mux_reduce_engine;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           up_vld, up_rdy, down_vld, down_rdy, busy;
    logic [N*W-1:0] up_data;
    logic [1:0]     up_mode;
    logic [W-1:0]   down_data;

    logic           up_vld1, up_rdy1, down_vld1, down_rdy1, busy1;
    logic [W-1:0]   up_data1, down_data1;
    logic [1:0]     up_mode1;

    mux_reduce_engine #(.WIDTH(W), .N_CH(N)) dut (
        .clk(clk), .rst(rst),
        .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data), .up_mode(up_mode),
        .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data), .busy(busy)
    );

    mux_reduce_engine #(.WIDTH(W), .N_CH(1)) dut1 (
        .clk(clk), .rst(rst),
        .up_vld(up_vld1), .up_rdy(up_rdy1), .up_data(up_data1), .up_mode(up_mode1),
        .down_vld(down_vld1), .down_rdy(down_rdy1), .down_data(down_data1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rdy_rand = 1'b0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    localparam logic [N*W-1:0] OR_VEC  = {8'h80, 8'h04, 8'h02, 8'h01};
    localparam logic [N*W-1:0] AND_VEC = {8'hFE, 8'h3C, 8'hF0, 8'hFF};
    localparam logic [N*W-1:0] XOR_VEC = {8'h0F, 8'hFF, 8'h55, 8'hAA};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain operators over the channel list.
    function automatic logic [W-1:0] ref_reduce(input logic [N*W-1:0] d,
                                                input logic [1:0] m, input int nch);
        logic [W-1:0] r;
        logic [W-1:0] c;
        r = d[W-1:0];
        for (int i = 1; i < nch; i++) begin
            c = d[i*W +: W];
            case (m)
                2'b01:   r = r & c;
                2'b10:   r = r ^ c;
                default: r = r | c;
            endcase
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rdy_rand) down_rdy = 1'($urandom_range(0, 1));
    end

    // Monitor: pops an expectation whenever a new result appears and checks
    // that a held result does not change.
    initial begin : monitor
        logic         prev_vld;
        logic [W-1:0] prev_data;
        logic [W-1:0] e;
        int           a;
        prev_vld  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                if (down_vld && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("down_data", 32'(down_data), 32'(e));
                        check("latency", 32'(cyc - a), 32'(N - 1));
                    end
                end else if (down_vld && prev_vld) begin
                    check("hold_data", 32'(down_data), 32'(prev_data));
                end
                prev_vld  = down_vld && !down_rdy;
                prev_data = down_data;
            end
        end
    end

    task automatic send(input logic [N*W-1:0] d, input logic [1:0] m, input bit toggle);
        int t = 0;
        while (!up_rdy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!up_rdy) begin
            check("up_rdy_timeout", 32'd0, 32'd1);
            return;
        end
        up_data = d;
        up_mode = m;
        up_vld  = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(ref_reduce(d, m, N));
        acc_q.push_back(cyc);
        up_vld  = 1'b0;
        up_data = $urandom;
        if (toggle) begin
            up_mode = ~m;
            @(posedge clk); #1;
            up_mode = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !up_rdy) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; up_vld = 1'b0; up_data = '0; up_mode = 2'b00; down_rdy = 1'b1;
        up_vld1 = 1'b0; up_data1 = '0; up_mode1 = 2'b00; down_rdy1 = 1'b1;
        #1;
        check("rst_up_rdy", 32'(up_rdy), 32'd1);
        check("rst_down_vld", 32'(down_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_down_data", 32'(down_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed vectors, including reserved mode and a mode toggle in RUN.
        send(OR_VEC, 2'b00, 1'b0);
        drain();
        send(AND_VEC, 2'b01, 1'b0);
        drain();
        send(OR_VEC, 2'b11, 1'b0);
        drain();
        send(XOR_VEC, 2'b10, 1'b1);
        drain();
        check("ref_or", 32'(ref_reduce(OR_VEC, 2'b00, N)), 32'h87);

        // Backpressure with a competing upstream request.
        down_rdy = 1'b0;
        send(OR_VEC, 2'b00, 1'b0);
        t = 0;
        while (!down_vld && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_reach_done", 32'(down_vld), 32'd1);
        up_data = XOR_VEC;
        up_mode = 2'b10;
        up_vld  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_down_vld", 32'(down_vld), 32'd1);
            check("bp_up_rdy", 32'(up_rdy), 32'd0);
            check("bp_data", 32'(down_data), 32'h87);
        end
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_up_rdy", 32'(up_rdy), 32'd1);
        check("bp_release_vld", 32'(down_vld), 32'd0);
        drain();

        // Reset in the middle of RUN.
        send(OR_VEC, 2'b00, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("mid_rst_down_vld", 32'(down_vld), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_up_rdy", 32'(up_rdy), 32'd1);
        check("mid_rst_down_data", 32'(down_data), 32'd0);
        @(negedge clk) rst = 1'b0;
        send(OR_VEC, 2'b00, 1'b0);
        drain();

        // Randomised traffic with random consumer stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_rand = 1'b0;
        @(negedge clk) down_rdy = 1'b1;

        // Single-channel instance.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] d;
            d = (i == 0) ? 8'h5A : W'($urandom);
            @(negedge clk);
            check("n1_up_rdy", 32'(up_rdy1), 32'd1);
            up_data1 = d;
            up_mode1 = 2'($urandom_range(0, 3));
            up_vld1  = 1'b1;
            @(posedge clk); #1;
            up_vld1 = 1'b0;
            check("n1_down_vld", 32'(down_vld1), 32'd1);
            check("n1_down_data", 32'(down_data1), 32'(ref_reduce({{(N-1)*W{1'b0}}, d}, up_mode1, 1)));
            check("n1_busy", 32'(busy1), 32'd1);
            @(posedge clk); #1;
            check("n1_idle", 32'(up_rdy1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
